// File: rtl/pq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pq_sched_ctrl
// Purpose  : Timer-driven scheduler for the AnTiQ array priority queue.
//            Keeps a saturating time base, arbitrates client PUSH requests
//            round-robin (turning relative delays into absolute deadlines),
//            accepts DROP requests, and POPs the head cell once its deadline
//            is reached, presenting it on a valid/ready expired-cell port.
//            At most one queue op per issue slot; every op is followed by
//            one quiet cycle so the queue's head/count can settle.
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            tick_i              - advance time base by one
//            now_o, time_sat_o   - current time, sticky saturation flag
//            req_valid/ready/delta/id - per-client push handshake (packed)
//            drop_valid/ready/id - drop handshake
//            pq_push/pop/drop_o  - queue op strobes (mutually exclusive)
//            pq_cell_o           - {data, id} for push; id for drop
//            pq_head_i, pq_cnt_i - queue head cell and occupancy
//            exp_valid/ready/id/time - expired-cell output handshake
// Revision : 1.0 - initial release
// ============================================================================
module pq_sched_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int QUEUE_DEPTH = 16,
  parameter int TIME_WIDTH  = 24,
  parameter int CNT_WIDTH   = $clog2(QUEUE_DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            tick_i,
  output logic [TIME_WIDTH-1:0]           now_o,
  output logic                            time_sat_o,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*TIME_WIDTH-1:0]   req_delta_i,
  input  logic [NUM_REQ*TIME_WIDTH-1:0]   req_id_i,
  input  logic                            drop_valid_i,
  output logic                            drop_ready_o,
  input  logic [TIME_WIDTH-1:0]           drop_id_i,
  output logic                            pq_push_o,
  output logic                            pq_pop_o,
  output logic                            pq_drop_o,
  output logic [2*TIME_WIDTH-1:0]         pq_cell_o,
  input  logic [2*TIME_WIDTH-1:0]         pq_head_i,
  input  logic [CNT_WIDTH:0]              pq_cnt_i,
  output logic                            exp_valid_o,
  input  logic                            exp_ready_i,
  output logic [TIME_WIDTH-1:0]           exp_id_o,
  output logic [TIME_WIDTH-1:0]           exp_time_o
);

  localparam int                    RR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIME_WIDTH-1:0] TIME_MAX = '1;
  localparam logic [CNT_WIDTH:0]    DEPTH    = (CNT_WIDTH+1)'(QUEUE_DEPTH);
  localparam logic [RR_W-1:0]       LAST_REQ = RR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t                  state;
  logic [TIME_WIDTH-1:0]   now;
  logic                    time_sat;
  logic [RR_W-1:0]         rr_ptr;
  logic                    exp_valid;
  logic [TIME_WIDTH-1:0]   exp_id;
  logic [TIME_WIDTH-1:0]   exp_time;

  logic [TIME_WIDTH-1:0]   head_data;
  logic [TIME_WIDTH-1:0]   head_id;
  logic                    issue_ok;
  logic                    head_due;
  logic                    do_pop;
  logic                    do_drop;
  logic                    do_push;
  logic                    grant_found;
  logic [RR_W-1:0]         grant;
  logic [TIME_WIDTH-1:0]   grant_delta;
  logic [TIME_WIDTH-1:0]   grant_id;
  logic [TIME_WIDTH:0]     deadline_sum;
  logic [TIME_WIDTH-1:0]   deadline;

  assign head_data = pq_head_i[2*TIME_WIDTH-1:TIME_WIDTH];
  assign head_id   = pq_head_i[TIME_WIDTH-1:0];

  // Ops only issue from IDLE; reset also silences the strobes so the queue
  // sees nothing while both blocks are being cleared.
  assign issue_ok = (state == IDLE) && !rst_i;
  assign head_due = (pq_cnt_i != '0) && (head_data <= now);

  assign do_pop  = issue_ok && head_due && (!exp_valid || exp_ready_i);
  assign do_drop = issue_ok && !do_pop && drop_valid_i;
  assign do_push = issue_ok && !do_pop && !drop_valid_i && grant_found &&
                   (pq_cnt_i < DEPTH);

  // Round-robin search: first valid client at or after rr_ptr, wrapping.
  always_comb begin : p_grant
    int              idx;
    logic [RR_W-1:0] sel;
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      sel = RR_W'(idx);
      if (!grant_found && req_valid_i[sel]) begin
        grant_found = 1'b1;
        grant       = sel;
      end
    end
  end

  always_comb begin : p_grant_fields
    grant_delta = '0;
    grant_id    = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (RR_W'(k) == grant) begin
        grant_delta    = req_delta_i[k*TIME_WIDTH +: TIME_WIDTH];
        grant_id       = req_id_i[k*TIME_WIDTH +: TIME_WIDTH];
        req_ready_o[k] = do_push;
      end
    end
  end

  // One extra sum bit catches overflow; overflowing deadlines clamp to max.
  assign deadline_sum = {1'b0, now} + {1'b0, grant_delta};
  assign deadline     = deadline_sum[TIME_WIDTH] ? TIME_MAX
                                                 : deadline_sum[TIME_WIDTH-1:0];

  always_comb begin : p_cell
    pq_cell_o = '0;
    if (do_push) begin
      pq_cell_o = {deadline, grant_id};
    end else if (do_drop) begin
      pq_cell_o = {{TIME_WIDTH{1'b0}}, drop_id_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      now       <= '0;
      time_sat  <= 1'b0;
      rr_ptr    <= '0;
      exp_valid <= 1'b0;
      exp_id    <= '0;
      exp_time  <= '0;
    end else begin
      // Saturating time base; the flag rises together with now reaching max.
      if (tick_i && (now != TIME_MAX)) begin
        now <= now + 1'b1;
        if (now == TIME_MAX - 1'b1) begin
          time_sat <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (do_pop || do_drop || do_push) begin
            state <= WAIT;
          end
        end
        WAIT:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (do_push) begin
        rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
      end

      // A pop in the consume cycle reloads rather than clears.
      if (do_pop) begin
        exp_valid <= 1'b1;
        exp_id    <= head_id;
        exp_time  <= head_data;
      end else if (exp_valid && exp_ready_i) begin
        exp_valid <= 1'b0;
      end
    end
  end

  assign now_o        = now;
  assign time_sat_o   = time_sat;
  assign drop_ready_o = do_drop;
  assign pq_push_o    = do_push;
  assign pq_pop_o     = do_pop;
  assign pq_drop_o    = do_drop;
  assign exp_valid_o  = exp_valid;
  assign exp_id_o     = exp_id;
  assign exp_time_o   = exp_time;

endmodule
`default_nettype wire

// File: tb/tb_pq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pq_sched_ctrl
// Purpose  : Self-checking bench for pq_sched_ctrl. A behavioural model of
//            the priority queue (sorted queue of cells) feeds the DUT's
//            head/count inputs, and a behavioural scheduler model predicts
//            every output each cycle. Random traffic, then directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pq_sched_ctrl;

  localparam int     NR   = 4;
  localparam int     QD   = 16;
  localparam int     TW   = 10;
  localparam int     CW   = $clog2(QD);
  localparam longint TMAX = (64'd1 << TW) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0;
  logic [TW-1:0]       now_o;
  logic                time_sat_o;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_ready_o;
  logic [NR*TW-1:0]    req_delta = '0;
  logic [NR*TW-1:0]    req_id = '0;
  logic                drop_valid = 1'b0;
  logic                drop_ready_o;
  logic [TW-1:0]       drop_id = '0;
  logic                pq_push_o, pq_pop_o, pq_drop_o;
  logic [2*TW-1:0]     pq_cell_o;
  logic [2*TW-1:0]     pq_head = '0;
  logic [CW:0]         pq_cnt = '0;
  logic                exp_valid_o;
  logic                exp_ready = 1'b1;
  logic [TW-1:0]       exp_id_o, exp_time_o;

  pq_sched_ctrl #(.NUM_REQ(NR), .QUEUE_DEPTH(QD), .TIME_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .now_o(now_o), .time_sat_o(time_sat_o),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_delta_i(req_delta),
    .req_id_i(req_id), .drop_valid_i(drop_valid), .drop_ready_o(drop_ready_o),
    .drop_id_i(drop_id), .pq_push_o(pq_push_o), .pq_pop_o(pq_pop_o),
    .pq_drop_o(pq_drop_o), .pq_cell_o(pq_cell_o), .pq_head_i(pq_head),
    .pq_cnt_i(pq_cnt), .exp_valid_o(exp_valid_o), .exp_ready_i(exp_ready),
    .exp_id_o(exp_id_o), .exp_time_o(exp_time_o)
  );

  always #5 clk = ~clk;

  typedef struct { longint data; longint id; } cell_t;
  cell_t  q[$];
  longint delta_a[NR];
  longint id_a[NR];

  // Scheduler reference state
  longint m_now = 0;
  bit     m_sat = 0;
  bit     m_busy = 0;
  int     m_rr = 0;
  bit     m_expv = 0;
  longint m_exp_id = 0;
  longint m_exp_time = 0;

  // Snapshot of what the DUT showed in the last checked cycle
  logic          s_push, s_pop, s_drop, s_expv, s_sat;
  logic [NR-1:0] s_rdy;
  logic [2*TW-1:0] s_cell;
  logic [TW-1:0] s_now, s_expid, s_exptime;
  int            cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_delta[k*TW +: TW] = TW'(delta_a[k]);
      req_id[k*TW +: TW]    = TW'(id_a[k]);
    end
    pq_cnt  = (CW+1)'(q.size());
    pq_head = (q.size() > 0) ? {TW'(q[0].data), TW'(q[0].id)} : '0;
  endtask

  // One clock cycle: predict, compare, advance the models.
  task automatic cycle();
    bit            e_pop, e_drop, e_push;
    int            g, c, pos;
    longint        dl;
    logic [NR-1:0] e_rdy;
    logic [2*TW-1:0] e_cell;
    cell_t         nc;
    drive();
    #1;
    e_pop = 0; e_drop = 0; e_push = 0; g = 0; c = 0;
    if (!rst && !m_busy) begin
      if (q.size() > 0 && q[0].data <= m_now && (!m_expv || exp_ready)) e_pop = 1;
      else if (drop_valid) e_drop = 1;
      else if (req_valid != 0 && q.size() < QD) begin
        e_push = 1;
        for (int k = 0; k < NR; k++) begin
          c = (m_rr + k) % NR;
          if (req_valid[c]) begin g = c; break; end
        end
      end
    end
    dl = m_now + delta_a[g];
    if (dl > TMAX) dl = TMAX;
    e_rdy  = e_push ? NR'(1 << g) : '0;
    e_cell = e_push ? {TW'(dl), TW'(id_a[g])} :
             e_drop ? {TW'(0), drop_id} : '0;

    s_push = pq_push_o; s_pop = pq_pop_o; s_drop = pq_drop_o; s_rdy = req_ready_o;
    s_cell = pq_cell_o; s_now = now_o; s_sat = time_sat_o; s_expv = exp_valid_o;
    s_expid = exp_id_o; s_exptime = exp_time_o;
    chk("pq_pop", 64'(pq_pop_o), 64'(e_pop));
    chk("pq_drop", 64'(pq_drop_o), 64'(e_drop));
    chk("pq_push", 64'(pq_push_o), 64'(e_push));
    chk("drop_ready", 64'(drop_ready_o), 64'(e_drop));
    chk("req_ready", 64'(req_ready_o), 64'(e_rdy));
    chk("pq_cell", 64'(pq_cell_o), 64'(e_cell));
    chk("now", 64'(now_o), 64'(m_now));
    chk("time_sat", 64'(time_sat_o), 64'(m_sat));
    chk("exp_valid", 64'(exp_valid_o), 64'(m_expv));
    chk("exp_id", 64'(exp_id_o), 64'(m_exp_id));
    chk("exp_time", 64'(exp_time_o), 64'(m_exp_time));

    @(posedge clk);
    cyc++;
    if (rst) begin
      m_now = 0; m_sat = 0; m_busy = 0; m_rr = 0;
      m_expv = 0; m_exp_id = 0; m_exp_time = 0;
      q.delete();
    end else begin
      if (e_pop) begin
        m_expv = 1; m_exp_id = q[0].id; m_exp_time = q[0].data;
        q.delete(0);
      end else if (m_expv && exp_ready) m_expv = 0;
      if (e_drop) begin
        for (int i = 0; i < q.size(); i++)
          if (q[i].id == longint'(drop_id)) begin q.delete(i); break; end
      end
      if (e_push) begin
        nc.data = dl; nc.id = id_a[g];
        pos = q.size();
        for (int i = 0; i < q.size(); i++)
          if (q[i].data > dl) begin pos = i; break; end
        q.insert(pos, nc);
        m_rr = (g + 1) % NR;
      end
      m_busy = e_pop || e_drop || e_push;
      if (tick && m_now < TMAX) begin
        m_now++;
        if (m_now == TMAX) m_sat = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  initial begin : main
    int grants[$];
    int gcyc[$];
    int exp_g[5];
    bit seen;
    exp_g = '{0, 1, 2, 3, 0};
    for (int k = 0; k < NR; k++) begin delta_a[k] = 0; id_a[k] = 0; end

    // Bring registers to a known state before checking starts.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    cycle();
    chk("reset_now", 64'(s_now), 64'd0);
    chk("reset_expv", 64'(s_expv), 64'd0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      tick      = ($urandom_range(0, 3) != 0);
      req_valid = NR'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int k = 0; k < NR; k++) begin
        delta_a[k] = $urandom_range(0, 30);
        id_a[k]    = $urandom_range(0, 1023);
      end
      drop_valid = ($urandom_range(0, 9) == 0);
      if (q.size() > 0 && $urandom_range(0, 9) < 7)
        drop_id = TW'(q[$urandom_range(0, q.size() - 1)].id);
      else
        drop_id = TW'($urandom_range(0, 1023));
      exp_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    // Reset in the middle of traffic
    do_reset();
    req_valid = '0; drop_valid = 0; exp_ready = 1; tick = 1;
    cycle();
    chk("midrst_now", 64'(s_now), 64'd0);
    chk("midrst_expv", 64'(s_expv), 64'd0);
    chk("midrst_push", 64'(s_push), 64'd0);

    // Client 1 pushes delta=5, id=0xA at now=10, pops at now=15
    for (int n = 0; n < 20 && m_now < 10; n++) cycle();
    chk("t2_now10", 64'(m_now), 64'd10);
    req_valid = 4'b0010; delta_a[1] = 5; id_a[1] = 'hA;
    cycle();
    req_valid = '0;
    chk("t2_push", 64'(s_push), 64'd1);
    chk("t2_cell", 64'(s_cell), {44'd0, TW'(15), TW'('hA)});
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cycle();
      seen = s_pop;
    end
    chk("t2_pop_seen", 64'(seen), 64'd1);
    chk("t2_pop_now", 64'(s_now), 64'd15);
    cycle();
    chk("t2_expv", 64'(s_expv), 64'd1);
    chk("t2_expid", 64'(s_expid), 64'hA);
    chk("t2_exptime", 64'(s_exptime), 64'd15);

    // Round-robin fairness with all clients valid, then fill the queue
    tick = 0;
    do_reset();
    for (int k = 0; k < NR; k++) begin delta_a[k] = 50 + k; id_a[k] = 'h100 + k; end
    req_valid = 4'b1111;
    for (int n = 0; n < 60 && q.size() < QD; n++) begin
      cycle();
      if (s_push) begin
        for (int k = 0; k < NR; k++) if (s_rdy[k]) grants.push_back(k);
        gcyc.push_back(cyc);
      end
    end
    chk("t3_filled", 64'(q.size()), 64'(QD));
    for (int i = 0; i < 5; i++) chk("t3_grant", 64'(grants[i]), 64'(exp_g[i]));
    for (int i = 1; i < 5; i++) chk("t3_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd2);
    cycle(); cycle();
    chk("t4_full_rdy", 64'(s_rdy), 64'd0);
    chk("t4_full_push", 64'(s_push), 64'd0);
    drop_valid = 1; drop_id = TW'(q[5].id);
    cycle();
    drop_valid = 0;
    chk("t4_drop", 64'(s_drop), 64'd1);
    chk("t4_drop_rdy", 64'(s_rdy), 64'd0);
    cycle(); cycle();
    req_valid = '0;

    // Expired head under backpressure does not block DROP
    do_reset();
    exp_ready = 1;
    delta_a[0] = 0; id_a[0] = 'h11; req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle(); cycle();
    chk("t5_pop1", 64'(s_pop), 64'd1);
    exp_ready = 0;
    cycle();
    id_a[0] = 'h22; req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    drop_valid = 1; drop_id = 'h33;
    cycle();
    drop_valid = 0;
    chk("t5_drop", 64'(s_drop), 64'd1);
    chk("t5_nopop", 64'(s_pop), 64'd0);
    chk("t5_held", 64'(s_expid), 64'h11);
    cycle();
    exp_ready = 1;
    cycle();
    chk("t5_pop2", 64'(s_pop), 64'd1);
    cycle();
    chk("t5_expid2", 64'(s_expid), 64'h22);

    // Clamped deadline and time-base saturation
    do_reset();
    tick = 1;
    for (int n = 0; n < 120 && m_now < 100; n++) cycle();
    delta_a[2] = TMAX; id_a[2] = 'h55; req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    chk("t6_clamp", 64'(s_cell), {44'd0, TW'(TMAX), TW'('h55)});
    seen = 0;
    for (int n = 0; n < 1100 && !m_sat; n++) begin
      cycle();
      if (s_pop) seen = 1;
    end
    repeat (4) begin
      cycle();
      if (s_pop) seen = 1;
    end
    chk("t6_sat", 64'(s_sat), 64'd1);
    chk("t6_now_hold", 64'(s_now), 64'(TMAX));
    chk("t6_popped", 64'(seen), 64'd1);
    chk("t6_expid", 64'(s_expid), 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
